// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave transaction controller.
package spi_pkg;

  // Transaction phases of one SPI frame (header, then data phase).
  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GOT_ADDR,
    READ_LOAD,
    READ_SHIFT,
    WRITE_RECV,
    WRITE_COMMIT,
    DONE
  } spiState_t;

  // Default frame-phase width and the matching bit-counter width.
  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned COUNT_W       = $clog2(DEFAULT_WIDTH + 1);

endpackage

// File: rtl/spi_bit_counter.sv
// Clearable, enabled up-counter that saturates at `width`.
// reachTerm flags the enabled increment that brings the count to `width`.
module spi_bit_counter #(
  parameter int unsigned width = spi_pkg::DEFAULT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         enable,
  output logic [$clog2(width+1)-1:0]   count,
  output logic                         reachTerm
);

  localparam int unsigned CW = $clog2(width + 1);
  localparam logic [CW-1:0] LAST = CW'(width - 1);
  localparam logic [CW-1:0] TERM = CW'(width);

  assign reachTerm = enable && (count == LAST);

  // Count enabled edges; clear has priority and the count never passes width.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != TERM)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/spi_slave_fsm.sv
// Transaction controller for the SPI slave datapath: sequences the header,
// address latch, read load/shift and write commit from CS and SCLK strobes.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        chip_select,
  input  logic                        sclk_rise,
  input  logic                        sclk_fall,
  input  logic                        rw_bit,
  output logic                        sr_parallel_load,
  output logic                        addr_write_enable,
  output logic                        dm_write_enable,
  output logic                        miso_enable,
  output logic [$clog2(width+1)-1:0]  bit_count
);

  spiState_t state;
  spiState_t stateNext;
  logic      cntClear;
  logic      cntEnable;
  logic      cntTerm;
  logic      countingPhase;

  // The falling strobe only drives the MISO flop directly, never the FSM.
  logic      unusedFall;
  assign unusedFall = sclk_fall;

  spi_bit_counter #(
    .width (width)
  ) bitCounter (
    .clk       (clk),
    .reset     (reset),
    .clear     (cntClear),
    .enable    (cntEnable),
    .count     (bit_count),
    .reachTerm (cntTerm)
  );

  // Counter control: count rises only in shifting phases, clear on every phase entry.
  // READ_SHIFT is not cleared on its last rise so DONE still shows the full count.
  always_comb begin
    countingPhase = (state == GET_ADDR) || (state == READ_SHIFT) || (state == WRITE_RECV);
    cntEnable     = sclk_rise && !chip_select && countingPhase;
    cntClear      = chip_select
                 || (state inside {IDLE, GOT_ADDR, READ_LOAD})
                 || (cntTerm && (state inside {GET_ADDR, WRITE_RECV}));
  end

  // Next-state logic; a deasserted chip select aborts from any state.
  always_comb begin
    stateNext = state;
    if (chip_select) begin
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE:         stateNext = GET_ADDR;
        GET_ADDR:     if (cntTerm) stateNext = GOT_ADDR;
        GOT_ADDR:     stateNext = rw_bit ? READ_LOAD : WRITE_RECV;
        READ_LOAD:    stateNext = READ_SHIFT;
        READ_SHIFT:   if (cntTerm) stateNext = DONE;
        WRITE_RECV:   if (cntTerm) stateNext = WRITE_COMMIT;
        WRITE_COMMIT: stateNext = DONE;
        DONE:         stateNext = DONE;
        default:      stateNext = IDLE;
      endcase
    end
  end

  // State register with Moore outputs registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      sr_parallel_load  <= 1'b0;
      addr_write_enable <= 1'b0;
      dm_write_enable   <= 1'b0;
      miso_enable       <= 1'b0;
    end else begin
      state             <= stateNext;
      sr_parallel_load  <= (stateNext == READ_LOAD);
      addr_write_enable <= (stateNext == GOT_ADDR);
      dm_write_enable   <= (stateNext == WRITE_COMMIT);
      miso_enable       <= (stateNext == READ_LOAD) || (stateNext == READ_SHIFT);
    end
  end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm: vector table plus scoreboard queue.
module tb_spi_slave_fsm;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum int {S_IDLE, S_GET, S_GOT, S_RLOAD, S_RSHIFT, S_WRECV, S_WCOMMIT, S_DONE} tbState_t;

  typedef struct {
    logic        rst;
    logic        cs;
    logic        rise;
    logic        fall;
    logic        rw;
    logic [3:0]  outs;   // {awe, dwe, miso, load}
    int unsigned cnt;
    string       tag;
  } vec_t;

  typedef struct {
    logic [3:0]  outs;
    int unsigned cnt;
    int          idx;
    string       tag;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          chip_select;
  logic          sclk_rise;
  logic          sclk_fall;
  logic          rw_bit;
  logic          sr_parallel_load;
  logic          addr_write_enable;
  logic          dm_write_enable;
  logic          miso_enable;
  logic [CW-1:0] bit_count;

  vec_t vecs[$];
  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  spi_slave_fsm #(.width(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .chip_select       (chip_select),
    .sclk_rise         (sclk_rise),
    .sclk_fall         (sclk_fall),
    .rw_bit            (rw_bit),
    .sr_parallel_load  (sr_parallel_load),
    .addr_write_enable (addr_write_enable),
    .dm_write_enable   (dm_write_enable),
    .miso_enable       (miso_enable),
    .bit_count         (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected enables for a given controller phase.
  function automatic logic [3:0] outsOf(input tbState_t s);
    case (s)
      S_GOT:     return 4'b1000;
      S_WCOMMIT: return 4'b0100;
      S_RLOAD:   return 4'b0011;
      S_RSHIFT:  return 4'b0010;
      default:   return 4'b0000;
    endcase
  endfunction

  // One vector: inputs for a cycle and the phase/count expected after its edge.
  task automatic add(input logic rst, input logic cs, input logic rise, input logic fall,
                     input logic rw, input tbState_t st, input int unsigned cnt, input string tag);
    vec_t v;
    v.rst = rst; v.cs = cs; v.rise = rise; v.fall = fall; v.rw = rw;
    v.outs = outsOf(st); v.cnt = cnt; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic csLow(input string tag);
    add(0, 0, 0, 0, 0, S_GET, 0, tag);
  endtask

  task automatic csHigh(input logic rise, input string tag);
    add(0, 1, rise, 0, 0, S_IDLE, 0, tag);
  endtask

  // Header: W rises with a gap cycle after each; the last gap leaves GOT_ADDR.
  task automatic header(input logic rw);
    for (int unsigned i = 1; i <= W; i++) begin
      if (i == W) begin
        add(0, 0, 1, 0, rw, S_GOT, 0, "hdrLast");
        add(0, 0, 0, 1, rw, rw ? S_RLOAD : S_WRECV, 0, "gotAddr");
      end else begin
        add(0, 0, 1, 0, rw, S_GET, i, "hdrRise");
        add(0, 0, 0, 1, rw, S_GET, i, "hdrGap");
      end
    end
  endtask

  // Read data phase, starting in READ_LOAD; optional rise during the load cycle.
  task automatic readData(input logic riseInLoad);
    add(0, 0, riseInLoad, 0, 1, S_RSHIFT, 0, "readLoad");
    for (int unsigned i = 1; i <= W; i++) begin
      add(0, 0, 1, 0, 1, (i == W) ? S_DONE : S_RSHIFT, i, "rdRise");
      add(0, 0, 0, 1, 1, (i == W) ? S_DONE : S_RSHIFT, i, "rdGap");
    end
  endtask

  // Write data phase of n rises, starting in WRITE_RECV.
  task automatic writeData(input int unsigned n);
    for (int unsigned i = 1; i <= n; i++) begin
      if (i == W) begin
        add(0, 0, 1, 0, 0, S_WCOMMIT, 0, "wrLast");
        add(0, 0, 0, 1, 0, S_DONE, 0, "wrCommit");
      end else begin
        add(0, 0, 1, 0, 0, S_WRECV, i, "wrRise");
        add(0, 0, 0, 1, 0, S_WRECV, i, "wrGap");
      end
    end
  endtask

  // Scoreboard checker: compares outputs 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0] act;
      e   = sb.pop_front();
      act = {addr_write_enable, dm_write_enable, miso_enable, sr_parallel_load};
      compared++;
      if (act !== e.outs) begin
        mismatched++;
        $display("FAIL %s[%0d] enables awe/dwe/miso/load: got %b expected %b", e.tag, e.idx, act, e.outs);
      end
      compared++;
      if (bit_count !== CW'(e.cnt)) begin
        mismatched++;
        $display("FAIL %s[%0d] bit_count: got %0d expected %0d", e.tag, e.idx, bit_count, e.cnt);
      end
      compared++;
      if (($countones(act) > 1) && (act !== 4'b0011)) begin
        mismatched++;
        $display("FAIL exclusive[%0d] enables: got %b expected at most one (or miso+load)", e.idx, act);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    chip_select = 1'b1;
    sclk_rise   = 1'b0;
    sclk_fall   = 1'b0;
    rw_bit      = 1'b0;

    // Reset held 3 cycles with CS low and strobes toggling.
    add(1, 0, 1, 0, 0, S_IDLE, 0, "reset");
    add(1, 0, 0, 1, 0, S_IDLE, 0, "reset");
    add(1, 0, 1, 0, 0, S_IDLE, 0, "reset");
    // Release: the rise coincident with leaving IDLE is not counted.
    add(0, 0, 1, 0, 0, S_GET, 0, "idleRise");
    // Write frame, header 0x54.
    header(1'b0);
    writeData(W);
    add(0, 0, 1, 0, 0, S_DONE, 0, "doneIgnore");
    csHigh(1'b0, "wrEnd");
    // Read frame, header 0x55.
    csLow("rdStart");
    header(1'b1);
    readData(1'b0);
    add(0, 0, 1, 0, 1, S_DONE, W, "doneIgnore");
    // Back-to-back reads with a single CS-high cycle; first has a rise during load.
    csHigh(1'b0, "b2bGap0");
    csLow("b2bStart1");
    header(1'b1);
    readData(1'b1);
    csHigh(1'b0, "b2bGap1");
    csLow("b2bStart2");
    header(1'b1);
    readData(1'b0);
    csHigh(1'b0, "b2bEnd");
    // Abort a write after 5 data rises.
    csLow("abStart");
    header(1'b0);
    writeData(5);
    csHigh(1'b0, "abort");
    csHigh(1'b1, "abortIdle");

    @(negedge clk);
    foreach (vecs[i]) begin
      exp_t e;
      reset       = vecs[i].rst;
      chip_select = vecs[i].cs;
      sclk_rise   = vecs[i].rise;
      sclk_fall   = vecs[i].fall;
      rw_bit      = vecs[i].rw;
      e.outs = vecs[i].outs;
      e.cnt  = vecs[i].cnt;
      e.idx  = i;
      e.tag  = vecs[i].tag;
      sb.push_back(e);
      @(posedge clk);
      #2;
    end
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
    @(posedge clk);
    #3;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboardDrain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
